// File: rtl/gray_seq_pkg.sv
// Shared types for the Gray-code sequencer: command opcodes,
// controller states and the binary-to-Gray helper.
package gray_seq_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_BURST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10
  } state_e;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_core.sv
// Binary/Gray count register pair with load, +/-1 step and wrap pulse.
// Ports: clk, rst (async low), en, dir, ld, ld_val -> bin, gray, wrap.
import gray_seq_pkg::*;

module gray_step_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    if (ld) begin
      next_bin = ld_val;
    end else if (en) begin
      if (dir) begin
        next_bin  = bin - WIDTH'(1);
        next_wrap = (bin == '0);
      end else begin
        next_bin  = bin + WIDTH'(1);
        next_wrap = (bin == '1);
      end
    end
  end

  // Gray is derived from next_bin so both registers
  // change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= WIDTH'(bin2gray(MAX_W'(next_bin)));
      wrap <= next_wrap;
    end
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command sequencer driving a Gray counter: LOAD/START/STOP/BURST.
// Ports: cmd_* handshake in, gray/bin/busy/done/wrap/cmd_err out.
import gray_seq_pkg::*;

module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_count,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cmd_err
);

  state_e           state, state_n;
  logic             dir_q, dir_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             done_n, err_n;
  logic             en, step_dir, ld;
  logic             accept;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state != S_BURST);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_n  = state;
    dir_n    = dir_q;
    rem_n    = rem;
    done_n   = 1'b0;
    err_n    = 1'b0;
    en       = 1'b0;
    ld       = 1'b0;
    step_dir = dir_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (op == OP_LOAD): begin
              ld     = 1'b1;
              done_n = 1'b1;
            end
            (op == OP_START): begin
              dir_n   = cmd_dir;
              state_n = S_RUN;
            end
            (op == OP_STOP): begin
            end
            (op == OP_BURST): begin
              if (cmd_count == '0) begin
                done_n = 1'b1;
              end else begin
                dir_n   = cmd_dir;
                rem_n   = cmd_count;
                state_n = S_BURST;
              end
            end
            default: begin
            end
          endcase
        end
      end
      S_RUN: begin
        en = 1'b1;
        if (accept) begin
          unique case (1'b1)
            (op == OP_STOP): begin
              en      = 1'b0;
              state_n = S_IDLE;
            end
            // Direction change takes effect on this same edge.
            (op == OP_START): begin
              dir_n    = cmd_dir;
              step_dir = cmd_dir;
            end
            default: begin
              err_n = 1'b1;
            end
          endcase
        end
      end
      S_BURST: begin
        en    = 1'b1;
        rem_n = rem - WIDTH'(1);
        if (rem == WIDTH'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      dir_q   <= 1'b0;
      rem     <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_n;
      dir_q   <= dir_n;
      rem     <= rem_n;
      done    <= done_n;
      cmd_err <= err_n;
    end
  end

  gray_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dir    (step_dir),
    .ld     (ld),
    .ld_val (cmd_data),
    .bin    (bin),
    .gray   (gray),
    .wrap   (wrap)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: directed scenarios
// followed by random commands against a behavioural model.
module tb_gray_seq_ctrl;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic         cmd_dir = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] cmd_count = '0;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         cmd_err;

  int tests = 0;
  int fails = 0;

  int m_bin  = 0;
  int m_mode = 0;
  int m_dir  = 0;
  int m_left = 0;
  int m_done = 0;
  int m_wrap = 0;
  int m_err  = 0;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .gray      (gray),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_bin  = 0;
    m_mode = 0;
    m_dir  = 0;
    m_left = 0;
    m_done = 0;
    m_wrap = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input int sd);
    m_wrap = ((sd == 0) && (m_bin == MODV - 1)) ||
             ((sd == 1) && (m_bin == 0)) ? 1 : 0;
    m_bin  = (sd != 0) ? (m_bin + MODV - 1) % MODV
                       : (m_bin + 1) % MODV;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bin"},   int'(bin),       m_bin);
    chk({tag, "_gray"},  int'(gray),      to_gray(m_bin));
    chk({tag, "_busy"},  int'(busy),      (m_mode != 0) ? 1 : 0);
    chk({tag, "_ready"}, int'(cmd_ready), (m_mode != 2) ? 1 : 0);
    chk({tag, "_done"},  int'(done),      m_done);
    chk({tag, "_wrap"},  int'(wrap),      m_wrap);
    chk({tag, "_err"},   int'(cmd_err),   m_err);
  endtask

  task automatic cyc(input bit v, input int op, input bit d,
                     input int data, input int n);
    bit acc;
    int sd;
    bit stepit;
    int dm;
    int nm;
    dm        = data & (MODV - 1);
    nm        = n & (MODV - 1);
    cmd_valid = v;
    cmd_op    = op[1:0];
    cmd_dir   = d;
    cmd_data  = dm[W-1:0];
    cmd_count = nm[W-1:0];
    #1;
    chk("ready_pre", int'(cmd_ready), (m_mode != 2) ? 1 : 0);
    acc = v && (m_mode != 2);
    @(posedge clk);
    m_done = 0;
    m_wrap = 0;
    m_err  = 0;
    case (m_mode)
      0: begin
        if (acc) begin
          case (op)
            0: begin
              m_bin  = dm;
              m_done = 1;
            end
            1: begin
              m_dir  = d;
              m_mode = 1;
            end
            3: begin
              if (nm == 0) m_done = 1;
              else begin
                m_dir  = d;
                m_left = nm;
                m_mode = 2;
              end
            end
            default: ;
          endcase
        end
      end
      1: begin
        sd     = m_dir;
        stepit = 1;
        if (acc) begin
          case (op)
            2: begin
              stepit = 0;
              m_mode = 0;
            end
            1: begin
              m_dir = d;
              sd    = d;
            end
            default: m_err = 1;
          endcase
        end
        if (stepit) model_step(sd);
      end
      default: begin
        model_step(m_dir);
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_done = 1;
        end
      end
    endcase
    #1;
    check_all("cyc");
    cmd_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("rst_gray", int'(gray), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    cyc(1, 0, 0, 5, 0);
    chk("ld5_bin", int'(bin), 5);
    chk("ld5_gray", int'(gray), 7);
    chk("ld5_done", int'(done), 1);
    chk("ld5_busy", int'(busy), 0);
    idle();
    chk("ld5_done_clr", int'(done), 0);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 3);
    chk("bst_ready0", int'(cmd_ready), 0);
    idle();
    chk("bst_g1", int'(gray), 1);
    idle();
    chk("bst_g2", int'(gray), 3);
    chk("bst_ready2", int'(cmd_ready), 0);
    idle();
    chk("bst_g3", int'(gray), 2);
    chk("bst_done", int'(done), 1);
    chk("bst_ready3", int'(cmd_ready), 1);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("dn_busy", int'(busy), 1);
    chk("dn_bin0", int'(bin), 0);
    idle();
    chk("dn_bin15", int'(bin), 15);
    chk("dn_gray8", int'(gray), 8);
    chk("dn_wrap", int'(wrap), 1);
    idle();
    chk("dn_wrap_clr", int'(wrap), 0);
    idle();
    cyc(1, 2, 0, 0, 0);
    chk("stop_bin", int'(bin), 13);
    chk("stop_busy", int'(busy), 0);
    idle();
    chk("stop_hold", int'(bin), 13);

    cyc(1, 3, 0, 0, 0);
    chk("b0_gray", int'(gray), 11);
    chk("b0_done", int'(done), 1);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    idle();
    idle();
    cyc(1, 0, 0, 9, 0);
    chk("run_ld_err", int'(cmd_err), 1);
    chk("run_ld_bin", int'(bin), 3);
    chk("run_ld_ne9", (bin != 4'd9) ? 1 : 0, 1);
    idle();
    chk("run_err_clr", int'(cmd_err), 0);
    chk("run_cont", int'(bin), 4);
    cyc(1, 1, 1, 0, 0);
    chk("run_rev", int'(bin), 3);
    cyc(1, 2, 0, 0, 0);

    cyc(1, 3, 0, 0, 4);
    cyc(1, 3, 1, 0, 2);
    chk("bb_ignored", int'(bin), 4);
    idle();
    idle();
    idle();
    chk("bb_bin", int'(bin), 7);
    chk("bb_done", int'(done), 1);

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (6) idle();
    chk("ar_bin6", int'(bin), 6);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_bin", int'(bin), 0);
    chk("ar_gray", int'(gray), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_ready", int'(cmd_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 6),
          int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)),
          int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
